// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: synchronous AXI-Stream FIFO with first-word-fall-through,
// a registered output stage, occupancy/packet counters and, in packet mode,
// store-and-forward with discard of bad or oversized packets.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int PKT_MODE     = 1,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                    clk_i,
  input  logic                    s_rst_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [ADDR_WIDTH:0]     count_o,
  output logic [ADDR_WIDTH:0]     pkt_count_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic                    drop_o,
  output logic                    overflow_o
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int PW         = ADDR_WIDTH + 1;
  localparam int WW         = DATA_WIDTH + KEEP_WIDTH + 1;  // {tlast, tkeep, tdata}

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THR  = PW'(DEPTH - ALMOST_FULL);
  localparam logic [PW-1:0] AE_THR  = PW'(ALMOST_EMPTY);
  localparam logic [PW-1:0] ONE     = PW'(1);

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_e;

  logic [WW-1:0] mem [DEPTH];

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic [WW-1:0] m_word_q, m_word_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          drop_q, drop_d;
  logic          overflow_q, overflow_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;

  logic [PW-1:0] used_w, committed_w, used_d;
  logic [WW-1:0] rd_word;
  logic          full_w, avail_w, s_ready_w, s_beat, m_hs, rd_en;
  logic          mem_we, pkt_inc, pkt_dec;

  // Occupancy is judged from pre-edge pointers only; there is no bypass.
  assign used_w      = wr_ptr_q - rd_ptr_q;
  assign committed_w = wr_commit_q - rd_ptr_q;
  assign full_w      = (used_w == DEPTH_P);
  assign avail_w     = (wr_commit_q != rd_ptr_q);

  // Mid-packet the sink never stalls: overflow is resolved by dropping.
  assign s_ready_w = ((PKT_MODE != 0) && (state_q != WR_IDLE)) || !full_w;
  assign s_beat    = s_axis_tvalid && s_ready_w;

  assign m_hs    = m_tvalid_q && m_axis_tready;
  assign rd_en   = avail_w && (!m_tvalid_q || m_axis_tready);
  assign rd_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign pkt_dec = (PKT_MODE != 0) && m_hs && m_word_q[WW-1];

  // Write-side FSM: store beats, then commit or rewind the packet on tlast.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    mem_we      = 1'b0;
    pkt_inc     = 1'b0;
    drop_d      = 1'b0;
    overflow_d  = 1'b0;
    if (PKT_MODE == 0) begin
      if (s_beat) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ONE;
      end
      wr_commit_d = wr_ptr_d;
    end else begin
      unique case (state_q)
        WR_IDLE, WR_PKT: begin
          if (s_beat) begin
            if (full_w) begin
              // Only reachable in PKT: IDLE backpressures when full.
              wr_ptr_d   = wr_commit_q;
              overflow_d = 1'b1;
              if (s_axis_tlast) begin
                drop_d  = 1'b1;
                state_d = WR_IDLE;
              end else begin
                state_d = WR_DROP;
              end
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE;
              if (s_axis_tlast) begin
                state_d = WR_IDLE;
                if (s_axis_tuser) begin
                  wr_ptr_d = wr_commit_q;
                  drop_d   = 1'b1;
                end else begin
                  wr_commit_d = wr_ptr_q + ONE;
                  pkt_inc     = 1'b1;
                end
              end else begin
                state_d = WR_PKT;
              end
            end
          end
        end
        WR_DROP: begin
          if (s_beat && s_axis_tlast) begin
            drop_d  = 1'b1;
            state_d = WR_IDLE;
          end
        end
        default: state_d = WR_IDLE;
      endcase
    end
  end

  // Read side: refill the output register when empty or being consumed.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    m_word_d   = m_word_q;
    m_tvalid_d = m_tvalid_q;
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + ONE;
      m_word_d   = rd_word;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
    pkt_count_d = pkt_count_q;
    if (PKT_MODE != 0) begin
      if (pkt_inc && !pkt_dec)      pkt_count_d = pkt_count_q + ONE;
      else if (!pkt_inc && pkt_dec) pkt_count_d = pkt_count_q - ONE;
    end
    used_d         = wr_ptr_d - rd_ptr_d;
    almost_full_d  = (used_d >= AF_THR);
    almost_empty_d = (used_d <= AE_THR);
  end

  // Packet storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the memory is deliberately not reset; pointers define validity.
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // State, pointers and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values.
    if (s_rst_i) begin
      state_q        <= WR_IDLE;
      wr_ptr_q       <= '0;
      wr_commit_q    <= '0;
      rd_ptr_q       <= '0;
      pkt_count_q    <= '0;
      m_word_q       <= '0;
      m_tvalid_q     <= 1'b0;
      drop_q         <= 1'b0;
      overflow_q     <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_commit_q    <= wr_commit_d;
      rd_ptr_q       <= rd_ptr_d;
      pkt_count_q    <= pkt_count_d;
      m_word_q       <= m_word_d;
      m_tvalid_q     <= m_tvalid_d;
      drop_q         <= drop_d;
      overflow_q     <= overflow_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign s_axis_tready  = s_ready_w;
  assign m_axis_tdata   = m_word_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep   = m_word_q[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast   = m_word_q[WW-1];
  assign m_axis_tvalid  = m_tvalid_q;
  assign count_o        = used_w;
  assign pkt_count_o    = pkt_count_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign drop_o         = drop_q;
  assign overflow_o     = overflow_q;

  a_used_bound: assert property (@(posedge clk_i) disable iff (s_rst_i) used_w <= DEPTH_P);
  a_commit_le_used: assert property (@(posedge clk_i) disable iff (s_rst_i) committed_w <= used_w);
  a_pkt_dec_valid: assert property (@(posedge clk_i) disable iff (s_rst_i)
    pkt_dec |-> (m_tvalid_q && pkt_count_q != '0));

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: a packet-mode instance (dut) and a
// streaming-mode instance (dut_s), both 16 words deep.
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

  typedef logic [36:0] word_t;  // {tlast, tkeep, tdata}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // packet-mode instance
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready = 1'b0;
  logic [4:0]  count, pkt_count;
  logic        afull, aempty, drop, ovf;

  // streaming-mode instance
  logic [31:0] z_s_tdata = '0;
  logic [3:0]  z_s_tkeep = '0;
  logic        z_s_tlast = 1'b0, z_s_tuser = 1'b0, z_s_tvalid = 1'b0, z_s_tready;
  logic [31:0] z_m_tdata;
  logic [3:0]  z_m_tkeep;
  logic        z_m_tlast, z_m_tvalid, z_m_tready = 1'b0;
  logic [4:0]  z_count, z_pkt_count;
  logic        z_afull, z_aempty, z_drop, z_ovf;

  axis_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PKT_MODE(1),
                  .ALMOST_FULL(2), .ALMOST_EMPTY(2)) dut (
    .clk_i(clk), .s_rst_i(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .count_o(count), .pkt_count_o(pkt_count), .almost_full_o(afull),
    .almost_empty_o(aempty), .drop_o(drop), .overflow_o(ovf));

  axis_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PKT_MODE(0),
                  .ALMOST_FULL(2), .ALMOST_EMPTY(2)) dut_s (
    .clk_i(clk), .s_rst_i(rst),
    .s_axis_tdata(z_s_tdata), .s_axis_tkeep(z_s_tkeep), .s_axis_tlast(z_s_tlast),
    .s_axis_tuser(z_s_tuser), .s_axis_tvalid(z_s_tvalid), .s_axis_tready(z_s_tready),
    .m_axis_tdata(z_m_tdata), .m_axis_tkeep(z_m_tkeep), .m_axis_tlast(z_m_tlast),
    .m_axis_tvalid(z_m_tvalid), .m_axis_tready(z_m_tready),
    .count_o(z_count), .pkt_count_o(z_pkt_count), .almost_full_o(z_afull),
    .almost_empty_o(z_aempty), .drop_o(z_drop), .overflow_o(z_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  // Output capture and pulse counting for the packet-mode instance.
  word_t out_q[$];
  int    drop_cnt = 0;
  int    ovf_cnt  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tkeep, m_tdata});
      if (drop) drop_cnt++;
      if (ovf)  ovf_cnt++;
    end
  end

  function automatic word_t mk(input logic [31:0] d, input logic last);
    return {last, d[3:0], d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after that edge.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic user);
    int budget = 0;
    s_tdata = d; s_tkeep = d[3:0]; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready) begin
      budget++;
      if (budget > 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_beat_timeout: tready=%b required 1", s_tready);
        s_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic clear_mon();
    out_q.delete(); drop_cnt = 0; ovf_cnt = 0;
  endtask

  task automatic test_reset();
    tick(2);
    rst = 1'b0;
    n_checks++; if ({m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty} !== 11'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b required 0", {m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty}); end
    n_checks++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
    n_checks++; if (pkt_count !== 5'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d required 0", pkt_count); end
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b required 1", s_tready); end
  endtask

  task automatic test_good_packet();
    logic [31:0] a [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    clear_mon();
    m_tready = 1'b1;
    send_beat(a[0], 1'b0, 1'b0);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid1: got %b required 0", m_tvalid); end
    send_beat(a[1], 1'b0, 1'b0);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid2: got %b required 0", m_tvalid); end
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL good_count_mid: got %0d required 2", count); end
    send_beat(a[2], 1'b1, 1'b0);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL good_valid_at_tlast: got %b required 0", m_tvalid); end
    n_checks++; if (pkt_count !== 5'd1) begin n_fail++; $display("FAIL good_pkt_count_1: got %0d required 1", pkt_count); end
    tick(1);
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL good_valid_after: got %b required 1", m_tvalid); end
    n_checks++; if (m_tdata !== a[0]) begin n_fail++; $display("FAIL good_first_data: got %h required %h", m_tdata, a[0]); end
    tick(4);
    n_checks++; if (out_q.size() != 3) begin n_fail++; $display("FAIL good_out_len: got %0d required 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== mk(a[i], i == 2)) begin n_fail++;
        $display("FAIL good_beat%0d: got %h required %h", i, out_q[i], mk(a[i], i == 2)); end
    end
    n_checks++; if (pkt_count !== 5'd0) begin n_fail++; $display("FAIL good_pkt_count_0: got %0d required 0", pkt_count); end
  endtask

  task automatic test_bad_packet();
    clear_mon();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hBAD0_0000 + i, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL bad_count_mid: got %0d required 4", count); end
    send_beat(32'hBAD0_0004, 1'b1, 1'b1);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL bad_count_rewind: got %0d required 0", count); end
    n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL bad_drop_pulse: got %b required 1", drop); end
    tick(1);
    n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL bad_drop_width: got %b required 0", drop); end
    tick(3);
    n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL bad_no_output: got %0d beats required 0", out_q.size()); end
    n_checks++; if (drop_cnt != 1) begin n_fail++; $display("FAIL bad_drop_cnt: got %0d required 1", drop_cnt); end
    send_beat(32'h0B0B_0005, 1'b0, 1'b0);
    send_beat(32'h0B0B_0006, 1'b1, 1'b0);
    tick(5);
    n_checks++; if (out_q.size() != 2) begin n_fail++; $display("FAIL bad_next_len: got %0d required 2", out_q.size()); end
    n_checks++; if (out_q.size() == 2 && (out_q[0] !== mk(32'h0B0B_0005, 1'b0) || out_q[1] !== mk(32'h0B0B_0006, 1'b1))) begin
      n_fail++; $display("FAIL bad_next_data: got %h %h required %h %h", out_q[0], out_q[1],
                         mk(32'h0B0B_0005, 1'b0), mk(32'h0B0B_0006, 1'b1)); end
  endtask

  task automatic test_overflow();
    clear_mon();
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL ovf_tready_beat%0d: got %b required 1", i, s_tready); end
      send_beat(32'hC000_0000 + i, i == 19, 1'b0);
      if (i == 15) begin
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count_full: got %0d required 16", count); end
      end
      if (i == 16) begin
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse_beat17: got %b required 1", ovf); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL ovf_count_rewind: got %0d required 0", count); end
      end
      if (i == 19) begin
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_at_tlast: got %b required 1", drop); end
      end
    end
    tick(3);
    n_checks++; if (ovf_cnt != 1) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 1", ovf_cnt); end
    n_checks++; if (drop_cnt != 1) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d required 1", drop_cnt); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL ovf_count_after: got %0d required 0", count); end
    n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_output: got %0d required 0", out_q.size()); end
    send_beat(32'h0D0D_0001, 1'b0, 1'b0);
    send_beat(32'h0D0D_0002, 1'b1, 1'b0);
    tick(5);
    n_checks++; if (out_q.size() != 2 || out_q[0] !== mk(32'h0D0D_0001, 1'b0) || out_q[1] !== mk(32'h0D0D_0002, 1'b1)) begin
      n_fail++; $display("FAIL ovf_reuse: got %0d beats, first %h required 2 beats, first %h",
                         out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, mk(32'h0D0D_0001, 1'b0)); end
  endtask

  task automatic test_fill_full();
    clear_mon();
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL fill_tready_%0d: got %b required 1", i, s_tready); end
      send_beat(32'hE000_0000 + i, 1'b1, 1'b0);
    end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL fill_tready_full: got %b required 0", s_tready); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d required 16", count); end
    n_checks++; if (pkt_count !== 5'd17) begin n_fail++; $display("FAIL fill_pkt_count: got %0d required 17", pkt_count); end
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hE000_0000) begin n_fail++;
      $display("FAIL fill_out_reg: got v=%b d=%h required v=1 d=e0000000", m_tvalid, m_tdata); end
    n_checks++; if (afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull: got %b required 1", afull); end
    // read and write presented in the same cycle while full
    m_tready = 1'b1;
    s_tdata = 32'h0000_0100; s_tkeep = 4'h0; s_tlast = 1'b1; s_tuser = 1'b0; s_tvalid = 1'b1;
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL fill_rw_tready: got %b required 0", s_tready); end
    tick(1);
    m_tready = 1'b0;
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL fill_rw_next_tready: got %b required 1", s_tready); end
    n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL fill_rw_count: got %0d required 15", count); end
    tick(1);
    s_tvalid = 1'b0;
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_rw_written: got %0d required 16", count); end
    m_tready = 1'b1;
    tick(25);
    n_checks++; if (out_q.size() != 18) begin n_fail++; $display("FAIL fill_drain_len: got %0d required 18", out_q.size()); end
    for (int i = 0; i < 18 && i < out_q.size(); i++) begin
      logic [31:0] d;
      d = (i == 17) ? 32'h0000_0100 : 32'hE000_0000 + i;
      n_checks++; if (out_q[i] !== mk(d, 1'b1)) begin n_fail++;
        $display("FAIL fill_drain_%0d: got %h required %h", i, out_q[i], mk(d, 1'b1)); end
    end
    n_checks++; if (pkt_count !== 5'd0 || count !== 5'd0) begin n_fail++;
      $display("FAIL fill_empty: got pkt=%0d cnt=%0d required 0 0", pkt_count, count); end
  endtask

  task automatic test_stream();
    word_t sb[$];
    int    occ = 0, beats_in = 0, beats_out = 0, cyc = 0, exp_cnt, pv, pr;
    bit    wr_hs = 1'b0, rd_hs, hit_af = 1'b0, hit_ae = 1'b0;
    word_t got;
    z_s_tvalid = 1'b0; z_m_tready = 1'b0;
    tick(2);
    while (beats_out < 10000 && cyc < 60000) begin
      cyc++;
      exp_cnt = occ - int'(z_m_tvalid);
      n_checks++; if (z_count !== 5'(exp_cnt)) begin n_fail++; $display("FAIL stream_count: got %0d required %0d", z_count, exp_cnt); end
      n_checks++; if (z_afull !== (exp_cnt >= 14)) begin n_fail++; $display("FAIL stream_afull: got %b count %0d", z_afull, exp_cnt); end
      n_checks++; if (z_aempty !== (exp_cnt <= 2)) begin n_fail++; $display("FAIL stream_aempty: got %b count %0d", z_aempty, exp_cnt); end
      if (exp_cnt >= 14) hit_af = 1'b1;
      if (exp_cnt <= 2)  hit_ae = 1'b1;
      case ((cyc / 300) % 3)
        0:       begin pv = 90; pr = 25; end
        1:       begin pv = 25; pr = 90; end
        default: begin pv = 70; pr = 70; end
      endcase
      if (!z_s_tvalid || wr_hs) begin
        if (beats_in < 10000 && $urandom_range(99, 0) < pv) begin
          z_s_tvalid = 1'b1; z_s_tdata = $urandom; z_s_tkeep = 4'($urandom);
          z_s_tlast = 1'($urandom); z_s_tuser = 1'($urandom);
        end else begin
          z_s_tvalid = 1'b0;
        end
      end
      z_m_tready = ($urandom_range(99, 0) < pr);
      wr_hs = z_s_tvalid && z_s_tready;
      rd_hs = z_m_tvalid && z_m_tready;
      if (rd_hs) begin
        got = {z_m_tlast, z_m_tkeep, z_m_tdata};
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL stream_underrun: got %h required nothing", got); end
        else begin
          if (got !== sb[0]) begin n_fail++; $display("FAIL stream_data: got %h required %h", got, sb[0]); end
          void'(sb.pop_front());
        end
        beats_out++;
      end
      if (wr_hs) begin
        sb.push_back({z_s_tlast, z_s_tkeep, z_s_tdata});
        beats_in++;
      end
      occ += int'(wr_hs) - int'(rd_hs);
      tick(1);
    end
    z_s_tvalid = 1'b0; z_m_tready = 1'b0;
    n_checks++; if (beats_out != 10000) begin n_fail++; $display("FAIL stream_beats: got %0d required 10000", beats_out); end
    n_checks++; if (!hit_af || !hit_ae) begin n_fail++; $display("FAIL stream_thresholds: got af=%b ae=%b required 1 1", hit_af, hit_ae); end
    n_checks++; if (z_pkt_count !== 5'd0 || z_drop !== 1'b0) begin n_fail++;
      $display("FAIL stream_pkt_count: got pkt=%0d drop=%b required 0 0", z_pkt_count, z_drop); end
  endtask

  task automatic test_reset_mid();
    // reset in the middle of a packet
    clear_mon();
    m_tready = 1'b1;
    send_beat(32'hF000_0001, 1'b0, 1'b0);
    send_beat(32'hF000_0002, 1'b0, 1'b0);
    s_tdata = 32'hF000_0003; s_tlast = 1'b0; s_tvalid = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0; s_tvalid = 1'b0;
    n_checks++; if ({m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty} !== 11'b0 || m_tdata !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_outputs: got %b %h required 0", {m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty}, m_tdata); end
    n_checks++; if (count !== 5'd0 || pkt_count !== 5'd0 || s_tready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_state: got cnt=%0d pkt=%0d rdy=%b required 0 0 1", count, pkt_count, s_tready); end
    // reset with the output register holding a stalled beat
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'hF100_0000 + i, 1'b1, 1'b0);
    tick(2);
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rststall_pre: got %b required 1", m_tvalid); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if ({m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty} !== 11'b0 || m_tdata !== 32'h0) begin n_fail++;
      $display("FAIL rststall_outputs: got %b %h required 0", {m_tvalid, m_tlast, m_tkeep, drop, ovf, afull, aempty}, m_tdata); end
    n_checks++; if (count !== 5'd0 || pkt_count !== 5'd0 || s_tready !== 1'b1) begin n_fail++;
      $display("FAIL rststall_state: got cnt=%0d pkt=%0d rdy=%b required 0 0 1", count, pkt_count, s_tready); end
    clear_mon();
    m_tready = 1'b1;
    send_beat(32'hF200_0007, 1'b1, 1'b0);
    tick(4);
    n_checks++; if (out_q.size() != 1 || out_q[0] !== mk(32'hF200_0007, 1'b1)) begin n_fail++;
      $display("FAIL rststall_after: got %0d beats, first %h required 1 beat %h",
               out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, mk(32'hF200_0007, 1'b1)); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_packet();
    test_overflow();
    test_fill_full();
    test_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
